// File: rtl/fft8_frame_loader.sv
// Collects serial complex samples into 8-sample frames and presents each frame
// in parallel to an 8-point FFT stage; in_sop realigns the frame boundary.
module fft8_frame_loader #(
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic                       in_sop,
  input  logic signed [DATA_W-1:0]   in_re,
  input  logic signed [DATA_W-1:0]   in_im,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [8*DATA_W-1:0]        out_re,
  output logic [8*DATA_W-1:0]        out_im,
  output logic                       sop_err
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1; valid never drops and data never changes until that transfer.

  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

  state_t            state, state_next;
  logic [2:0]        wr_cnt;
  logic [DATA_W-1:0] buf_re [8];
  logic [DATA_W-1:0] buf_im [8];

  logic       accept;
  logic       frame_done;
  logic       load_direct;
  logic       load_held;
  logic [2:0] slot;

  assign in_ready   = (state == FILL);
  assign accept     = in_valid && in_ready;
  assign slot       = in_sop ? 3'd0 : wr_cnt;
  assign frame_done = accept && !in_sop && (wr_cnt == 3'd7);

  always_comb begin
    state_next  = state;
    load_direct = 1'b0;
    load_held   = 1'b0;
    case (state)
      FILL: begin
        if (frame_done) begin
          if (!out_valid || out_ready) load_direct = 1'b1;
          else                         state_next  = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          load_held  = 1'b1;
          state_next = FILL;
        end
      end
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FILL;
    else     state <= state_next;
  end

  // Slot 7 is written to the buffer too, so a frame parked in HOLD is complete.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt  <= 3'd0;
      sop_err <= 1'b0;
      for (int k = 0; k < 8; k++) begin
        buf_re[k] <= '0;
        buf_im[k] <= '0;
      end
    end else begin
      sop_err <= accept && in_sop && (wr_cnt != 3'd0);
      if (accept) begin
        buf_re[slot] <= in_re;
        buf_im[slot] <= in_im;
        wr_cnt       <= in_sop ? 3'd1 : wr_cnt + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
    end else if (load_direct) begin
      for (int k = 0; k < 7; k++) begin
        out_re[k*DATA_W +: DATA_W] <= buf_re[k];
        out_im[k*DATA_W +: DATA_W] <= buf_im[k];
      end
      out_re[7*DATA_W +: DATA_W] <= in_re;
      out_im[7*DATA_W +: DATA_W] <= in_im;
      out_valid <= 1'b1;
    end else if (load_held) begin
      for (int k = 0; k < 8; k++) begin
        out_re[k*DATA_W +: DATA_W] <= buf_re[k];
        out_im[k*DATA_W +: DATA_W] <= buf_im[k];
      end
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft8_frame_loader.sv
// Bench for fft8_frame_loader: directed scenarios plus randomized traffic,
// checked against a frame-queue model of the loader.
module tb_fft8_frame_loader;
  localparam int W  = 32;
  localparam int FW = 8 * W;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_sop = 1'b0;
  logic signed [W-1:0] in_re = '0;
  logic signed [W-1:0] in_im = '0;
  logic                out_ready = 1'b0;
  logic                in_ready;
  logic                out_valid;
  logic                sop_err;
  logic [FW-1:0]       out_re;
  logic [FW-1:0]       out_im;

  fft8_frame_loader #(.DATA_W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_sop    (in_sop),
    .in_re     (in_re),
    .in_im     (in_im),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .sop_err   (sop_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int   n_checks = 0;
  int   n_pass   = 0;
  logic rnd_ready = 1'b0;

  task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  // reference model: samples of the partial frame, and frames owed downstream
  logic [W-1:0]  coll_re[$];
  logic [W-1:0]  coll_im[$];
  logic [FW-1:0] exp_re_q[$];
  logic [FW-1:0] exp_im_q[$];
  logic          exp_err = 1'b0;

  // scoreboard monitor
  always @(negedge clk) begin : monitor
    int            owed;
    logic          hs;
    logic          acc;
    logic [FW-1:0] fr;
    logic [FW-1:0] fi;
    if (rst) begin
      check("rst_out_valid", FW'(out_valid), FW'(0));
      check("rst_in_ready",  FW'(in_ready),  FW'(1));
      check("rst_sop_err",   FW'(sop_err),   FW'(0));
      check("rst_out_re",    out_re, '0);
      check("rst_out_im",    out_im, '0);
      coll_re.delete();  coll_im.delete();
      exp_re_q.delete(); exp_im_q.delete();
      exp_err = 1'b0;
    end else begin
      owed = exp_re_q.size();
      check("out_valid", FW'(out_valid), FW'(owed > 0));
      check("in_ready",  FW'(in_ready),  FW'(owed < 2));
      check("sop_err",   FW'(sop_err),   FW'(exp_err));
      if (owed > 0) begin
        check("frame_re", out_re, exp_re_q[0]);
        check("frame_im", out_im, exp_im_q[0]);
      end
      hs  = (owed > 0) && out_ready;
      acc = in_valid && (owed < 2);
      exp_err = 1'b0;
      if (hs) begin
        void'(exp_re_q.pop_front());
        void'(exp_im_q.pop_front());
      end
      if (acc) begin
        if (in_sop) begin
          exp_err = (coll_re.size() != 0);
          coll_re.delete();
          coll_im.delete();
        end
        coll_re.push_back(in_re);
        coll_im.push_back(in_im);
        if (coll_re.size() == 8) begin
          fr = '0;
          fi = '0;
          for (int k = 0; k < 8; k++) begin
            fr[k*W +: W] = coll_re[k];
            fi[k*W +: W] = coll_im[k];
          end
          exp_re_q.push_back(fr);
          exp_im_q.push_back(fi);
          coll_re.delete();
          coll_im.delete();
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [W-1:0] re, input logic [W-1:0] im, input logic sop);
    logic r;
    int   n;
    in_valid = 1'b1;
    in_sop   = sop;
    in_re    = re;
    in_im    = im;
    n = 0;
    forever begin
      @(negedge clk);
      r = in_ready;
      tick();
      if (r) break;
      n++;
      if (n > 200) begin
        n_checks++;
        $display("FAIL send_timeout: got no accept after %0d cycles expected accept", n);
        break;
      end
    end
    in_valid = 1'b0;
    in_sop   = 1'b0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  initial begin
    logic [W-1:0] v;
    idle(3);
    rst = 1'b0;
    idle(1);

    // basic frame
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) send(W'(k), W'(-k), 1'b0);
    @(negedge clk);
    check("basic_re0", FW'(out_re[0*W +: W]), FW'(32'd1));
    check("basic_re7", FW'(out_re[7*W +: W]), FW'(32'd8));
    check("basic_im3", FW'(out_im[3*W +: W]), FW'(32'hFFFF_FFFC));
    idle(3);

    // back-to-back
    for (int k = 0; k < 16; k++) send(W'(k + 20), W'(k + 40), 1'b0);
    idle(3);

    // backpressure into HOLD, single-cycle release, then drain
    out_ready = 1'b0;
    for (int k = 0; k < 16; k++) send($urandom, $urandom, 1'b0);
    idle(3);
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
    idle(3);
    out_ready = 1'b1;
    idle(3);

    // realign after 3 samples
    for (int k = 0; k < 3; k++) send(W'(k + 60), W'(k + 70), 1'b0);
    send(W'(100), W'(200), 1'b1);
    for (int k = 1; k < 8; k++) send(W'(k + 100), W'(k + 200), 1'b0);
    @(negedge clk);
    check("realign_re0", FW'(out_re[0*W +: W]), FW'(32'd100));
    check("realign_re1", FW'(out_re[1*W +: W]), FW'(32'd101));
    idle(3);

    // mid-frame reset, then a full frame without in_sop
    for (int k = 0; k < 5; k++) send($urandom, $urandom, 1'b0);
    do_reset();
    for (int k = 0; k < 8; k++) send(W'(k + 300), W'(k + 400), 1'b0);
    @(negedge clk);
    check("post_rst_re0", FW'(out_re[0*W +: W]), FW'(32'd300));
    idle(3);

    // reset while in HOLD
    out_ready = 1'b0;
    for (int k = 0; k < 16; k++) send($urandom, $urandom, 1'b0);
    idle(2);
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) send(W'(k + 500), W'(k + 600), 1'b0);
    idle(3);

    // sign and width extremes
    for (int k = 0; k < 8; k++) begin
      v = k[0] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      send(v, ~v, 1'b0);
    end
    @(negedge clk);
    check("sign_re0", FW'(out_re[0*W +: W]), FW'(32'h7FFF_FFFF));
    check("sign_re1", FW'(out_re[1*W +: W]), FW'(32'h8000_0000));
    check("sign_im1", FW'(out_im[1*W +: W]), FW'(32'h7FFF_FFFF));
    idle(3);

    // randomized traffic with random backpressure and occasional realign
    rnd_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      send($urandom, $urandom, ($urandom_range(0, 11) == 0));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    idle(10);
    check("drain_empty", FW'(exp_re_q.size()), FW'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fft8_frame_loader.md
FFT8_FRAME_LOADER -- requirements
Module: fft8_frame_loader

Interface
REQ-001 The block SHALL have one parameter: DATA_W, default 32, the signed width of each real and imaginary sample.
REQ-002 The block SHALL use one clock and an asynchronous, active-high reset; the ports are listed below, one per line.
- clk  input  1  clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  an input sample is offered.
- in_sop  input  1  the offered sample is sample 0 of a frame; qualified by in_valid.
- in_re  input  DATA_W  signed real part of the sample.
- in_im  input  DATA_W  signed imaginary part of the sample.
- in_ready  output  1  the block accepts a sample this cycle.
- out_valid  output  1  a complete 8-sample frame is presented.
- out_ready  input  1  the downstream 8-point FFT stage consumes the frame.
- out_re  output  8*DATA_W  real parts of the frame; slot k is at bits [k*DATA_W +: DATA_W].
- out_im  output  8*DATA_W  imaginary parts of the frame; slots are packed as for out_re.
- sop_err  output  1  one-cycle pulse when a frame was realigned and a partial frame was dropped.

Function
REQ-003 Purpose: the block SHALL collect serial complex samples into 8-sample frames and present each frame in parallel to the downstream 8-point FFT stage; slot 0 feeds input a/ai and slot 7 feeds input h/hi of that stage.
REQ-004 Accept rule: a sample SHALL be accepted on a rising edge only when in_valid=1 and in_ready=1; when in_valid=0 the block SHALL hold all state.
REQ-005 A 3-bit write counter wr_cnt SHALL select the slot for each accepted sample; after each accept it SHALL increment and wrap from 7 to 0.
REQ-006 Realign: an accept with in_sop=1 SHALL write the sample to slot 0 and set wr_cnt to 1, whatever the current wr_cnt value.
REQ-007 If an in_sop=1 accept occurs while wr_cnt is not 0, the samples already collected SHALL be discarded and sop_err SHALL be 1 for exactly the following cycle.
REQ-008 The FSM SHALL have two states, FILL and HOLD; in_ready SHALL be 1 in FILL and 0 in HOLD.
REQ-009 Frame completion: an accept that writes slot 7 (and is not an in_sop accept) completes a frame.
REQ-010 On frame completion, if out_valid=0 or out_ready=1 in that cycle, the block SHALL load the output registers on that same edge.
- Slots 0..6 are loaded from the collection buffer; slot 7 is loaded from the incoming sample.
- out_valid SHALL be 1 from the next cycle (latency 1 cycle after the 8th accept), and the state SHALL remain FILL.
REQ-011 On frame completion with out_valid=1 and out_ready=0, the state SHALL go to HOLD and the completed frame SHALL be kept in the collection buffer.
REQ-012 In HOLD, on the first edge where out_ready=1, the buffered frame SHALL be loaded into the output registers, out_valid SHALL remain 1, and the state SHALL return to FILL.
REQ-013 When out_valid=1 and out_ready=1 and no new frame is loaded on that edge, out_valid SHALL be 0 from the next cycle.
REQ-014 When out_valid=1 and out_ready=0, out_re and out_im SHALL hold stable; out_valid SHALL NOT drop without a handshake.
REQ-015 The block SHALL sustain one sample per cycle when out_ready=1 continuously, with no bubbles between frames.
REQ-016 Data SHALL pass through bit-exact, with no arithmetic, rounding or sign change; out_re and out_im SHALL be registered outputs.
REQ-017 out_re and out_im SHALL keep the last frame after the handshake; their value is don't-care while out_valid=0.

Reset
REQ-018 While rst=1, asynchronously, the block SHALL force:
- state=FILL, wr_cnt=0;
- in_ready=1, out_valid=0, sop_err=0;
- out_re=0, out_im=0, collection buffer=0.
REQ-019 A reset during a partial frame or in HOLD SHALL discard all collected and pending data; the first accept after reset SHALL be treated as slot 0, regardless of in_sop.

Verification
REQ-020 The bench SHALL cover the following directed scenarios.
- Basic frame: reset, then 8 consecutive accepts in_re=1..8, in_im=-1..-8, out_ready=1 -> out_valid=1 in the cycle after the 8th accept; out_re slot0=1 and slot7=8; out_im slot3=-4; out_valid=0 one cycle later.
- Back-to-back: 16 samples streamed with out_ready=1 -> two frames, out_valid high for 1 cycle after accept 8 and for 1 cycle after accept 16, in_ready=1 throughout.
- Backpressure: out_ready=0 while 16 samples are offered -> frame 1 is held stable; after accept 16, in_ready=0 (HOLD); raising out_ready for 1 cycle -> frame 2 presented, in_ready=1.
- Realign: 3 samples accepted, then in_sop=1 with in_re=100 -> sop_err pulses 1 cycle; the next frame has slot0=100 and contains none of the 3 earlier samples.
- Mid-frame reset: 5 samples accepted, then rst pulsed -> all outputs return to reset values; the next 8 samples form a full frame starting at slot 0.
- Sign/width: slot values 0x7FFFFFFF and 0x80000000 at DATA_W=32 -> appear unchanged at out_re.
